// File: rtl/sobel_column_engine.sv
// sobel_column_engine: 3x3 Sobel |Gx|+|Gy| over software-paced pixel columns, 3-stage pipeline.
// Optional binarisation of the result is enabled with `define SOBEL_THRESH_EN.
module sobel_column_engine #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pix_word,
    output logic [7:0]  result,
    output logic        result_vld,
    output logic        ack_tog,
    output logic [31:0] status
);
    logic [23:0]        c0, c1, c2;
    logic [1:0]         col_cnt;
    logic               v0, v1;
    logic signed [10:0] gx, gy, gx_c, gy_c;
    logic [10:0]        ax, ay;
    logic [11:0]        mag;
    logic [7:0]         sat, res_c;
    logic [CNT_W-1:0]   result_cnt;
    logic [CNT_W+15:0]  cnt_ext;
    logic               accept, sor;
    logic               unused;

    function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {3'b0, a} + {2'b0, b, 1'b0} + {3'b0, c};
    endfunction

    assign accept  = pix_word[24] != ack_tog;
    assign sor     = pix_word[25];
    assign unused  = ^pix_word[31:26];
    // Column bytes: [7:0] top, [15:8] mid, [23:16] bottom
    assign gx_c    = $signed(wsum(c2[7:0], c2[15:8], c2[23:16]) - wsum(c0[7:0], c0[15:8], c0[23:16]));
    assign gy_c    = $signed(wsum(c0[23:16], c1[23:16], c2[23:16]) - wsum(c0[7:0], c1[7:0], c2[7:0]));
    assign ax      = gx[10] ? 11'(-gx) : 11'(gx);
    assign ay      = gy[10] ? 11'(-gy) : 11'(gy);
    assign mag     = {1'b0, ax} + {1'b0, ay};
    assign sat     = |mag[11:8] ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESH_EN
    assign res_c   = ({24'b0, sat} >= 32'(THRESH)) ? 8'hFF : 8'h00;
`else
    logic [7:0] unused_thresh;
    assign unused_thresh = 8'(THRESH);
    assign res_c   = sat;
`endif
    assign cnt_ext = {16'b0, result_cnt};
    assign status  = {cnt_ext[15:0], 7'b0, ack_tog, result};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c0         <= '0;
            c1         <= '0;
            c2         <= '0;
            col_cnt    <= '0;
            v0         <= 1'b0;
            v1         <= 1'b0;
            gx         <= '0;
            gy         <= '0;
            result     <= '0;
            result_vld <= 1'b0;
            ack_tog    <= 1'b0;
            result_cnt <= '0;
        end else begin
            v0 <= 1'b0;
            if (accept) begin
                ack_tog <= pix_word[24];
                c2      <= pix_word[23:0];
                c1      <= sor ? 24'b0 : c2;
                c0      <= sor ? 24'b0 : c1;
                col_cnt <= sor ? 2'd1 : (col_cnt == 2'd3 ? 2'd3 : col_cnt + 2'd1);
                v0      <= !sor && col_cnt >= 2'd2;
            end
            v1 <= v0;
            if (v0) begin
                gx <= gx_c;
                gy <= gy_c;
            end
            result_vld <= v1;
            if (v1) begin
                result     <= res_c;
                result_cnt <= result_cnt + 1'b1;
            end
        end
    end
endmodule
